// File: rtl/bram_arb2.sv
// Two-port round-robin arbiter in front of a single-port BRAM with 1-cycle read latency.
// Optional power-up clear sweep enabled by defining BRAM_ARB2_CLEAR_EN.
module bram_arb2 #(
  parameter int AW = 5,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Index of the most recent grant; reset to 1 so requester 0 wins first contention.
  logic last;
  logic run;
  logic clearing;

`ifdef BRAM_ARB2_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt + AW'(1);
      if (cnt == '1) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end
  end

  assign run      = (state == RUN);
  assign clearing = (state == CLEAR) && !rst;
`else
  assign busy     = 1'b0;
  assign run      = 1'b1;
  assign clearing = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run && !rst) begin
      if (req0 && (!req1 || last))
        gnt0 = 1'b1;
      else if (req1)
        gnt1 = 1'b1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (clearing) begin
`ifdef BRAM_ARB2_CLEAR_EN
      mem_we   = 1'b1;
      mem_addr = cnt;
`endif
    end else if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0)
        last <= 1'b0;
      else if (gnt1)
        last <= 1'b1;
    end
  end

  assign rdata0 = rvalid0 ? mem_rdata : '0;
  assign rdata1 = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_bram_arb2.sv
// Directed self-checking bench for bram_arb2 with a behavioural single-port BRAM.
// Clear-sweep scenarios run only when BRAM_ARB2_CLEAR_EN is defined.
module tb_bram_arb2;

  localparam int AW = 5;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  bram_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Read-first synchronous BRAM, pre-filled with 4'hF so a clear is observable.
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 4'hF;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i * 7 + 3) % 16);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    for (int n = 0; busy && n < 40; n++) cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_ready: busy=%b required 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 5'd1; addr1 = 5'd2;
    cyc(); #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b required 0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b required 0", gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    cyc();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid0: got %b required 0", rvalid0); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid1: got %b required 0", rvalid1); end
    checks++; if (rdata0 !== 4'h0) begin errors++; $display("FAIL reset_rdata0: got %h required 0", rdata0); end
`ifdef BRAM_ARB2_CLEAR_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
`endif
    cyc();
  endtask

`ifdef BRAM_ARB2_CLEAR_EN
  task automatic test_clear();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== 4'h0 || gnt0 !== 1'b0) begin
        errors++;
        $display("FAIL clear_sweep[%0d]: busy=%b we=%b addr=%0d wdata=%h gnt0=%b required 1,1,%0d,0,0",
                 i, busy, mem_we, mem_addr, mem_wdata, gnt0, i);
      end
      cyc();
    end
    req0 = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy: got %b required 0", busy); end
    req0 = 1'b1; addr0 = 5'd17;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clear_read_gnt: got %b required 1", gnt0); end
    cyc();
    req0 = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'h0) begin
      errors++; $display("FAIL clear_read17: rvalid0=%b rdata0=%h required 1,0", rvalid0, rdata0);
    end
    cyc();
  endtask

  task automatic test_clear_restart();
    do_reset();
    for (int i = 0; i < 10; i++) cyc();
    #1;
    checks++; if (mem_addr !== 5'd10) begin errors++; $display("FAIL restart_pre_addr: got %0d required 10", mem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL restart_rst_we: got %b required 0", mem_we); end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || mem_addr !== AW'(i)) begin
        errors++; $display("FAIL restart_sweep[%0d]: busy=%b addr=%0d required 1,%0d", i, busy, mem_addr, i);
      end
      cyc();
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_done: busy=%b required 0", busy); end
  endtask
`endif

  task automatic test_write_read();
    wait_ready();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 4'b1010;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt: gnt0=%b gnt1=%b required 1,0", gnt0, gnt1); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd5 || mem_wdata !== 4'b1010) begin
      errors++; $display("FAIL wr_mem: we=%b addr=%0d wdata=%h required 1,5,a", mem_we, mem_addr, mem_wdata);
    end
    cyc();
    we0 = 1'b0; wdata0 = 4'h0;
    #1;
    checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd5) begin
      errors++; $display("FAIL rd_gnt: gnt0=%b we=%b addr=%0d required 1,0,5", gnt0, mem_we, mem_addr);
    end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b required 0", rvalid0); end
    cyc();
    req0 = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'b1010) begin
      errors++; $display("FAIL rd_data: rvalid0=%b rdata0=%h required 1,a", rvalid0, rdata0);
    end
    checks++; if (gnt0 !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 4'h0) begin
      errors++; $display("FAIL idle_mem: gnt0=%b we=%b addr=%0d wdata=%h required all 0", gnt0, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    #1;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 4'h0 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd_single: rvalid0=%b rdata0=%h rvalid1=%b required 0,0,0", rvalid0, rdata0, rvalid1);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] ea;
    do_reset();
    wait_ready();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 5'd3; addr1 = 5'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      ea = (k % 2 == 0) ? 5'd3 : 5'd7;
      checks++;
      if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1) || mem_addr !== ea) begin
        errors++; $display("FAIL contend[%0d]: gnt0=%b gnt1=%b addr=%0d required %b,%b,%0d",
                           k, gnt0, gnt1, mem_addr, k % 2 == 0, k % 2 == 1, ea);
      end
      if (k > 0) begin
        checks++;
        if (rvalid0 !== (k % 2 == 1) || rvalid1 !== (k % 2 == 0)) begin
          errors++; $display("FAIL contend_rvalid[%0d]: rvalid0=%b rvalid1=%b required %b,%b",
                             k, rvalid0, rvalid1, k % 2 == 1, k % 2 == 0);
        end
      end
      cyc();
    end
    // Pointer now favours requester 0, yet a lone requester 1 must still win.
    req0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lone1[%0d]: gnt0=%b gnt1=%b required 0,1", k, gnt0, gnt1); end
      cyc();
    end
    req1 = 1'b0; req0 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL lone0: gnt0=%b gnt1=%b required 1,0", gnt0, gnt1); end
    cyc();
    req0 = 1'b0;
    cyc();
  endtask

  task automatic test_sweep();
    wait_ready();
    for (int i = 0; i < 32; i++) begin
      req0 = 1'b1; we0 = 1'b1; addr0 = AW'(i); wdata0 = pat(i);
      #1;
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL sweep_wr[%0d]: gnt0=%b required 1", i, gnt0); end
      cyc();
    end
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (k < 32) addr1 = AW'(k); else req1 = 1'b0;
      #1;
      if (k < 32) begin
        checks++;
        if (gnt1 !== 1'b1 || mem_addr !== AW'(k)) begin
          errors++; $display("FAIL sweep_gnt[%0d]: gnt1=%b addr=%0d required 1,%0d", k, gnt1, mem_addr, k);
        end
      end
      if (k > 0) begin
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== pat(k - 1)) begin
          errors++; $display("FAIL sweep_rd[%0d]: rvalid1=%b rdata1=%h required 1,%h", k - 1, rvalid1, rdata1, pat(k - 1));
        end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_read();
    wait_ready();
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5; req1 = 1'b0;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL midrst_pre: gnt0=%b required 1", gnt0); end
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midrst_gnt: gnt0=%b we=%b required 0,0", gnt0, mem_we); end
    cyc();
    rst = 1'b0; req0 = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 4'h0) begin
      errors++; $display("FAIL midrst_rvalid: rvalid0=%b rdata0=%h required 0,0", rvalid0, rdata0);
    end
    wait_ready();
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 5'd9;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL midrst_first: gnt0=%b gnt1=%b required 1,0", gnt0, gnt1); end
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
`ifdef BRAM_ARB2_CLEAR_EN
    test_clear();
    test_clear_restart();
`endif
    test_write_read();
    test_contention();
    test_sweep();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
